sar_adc_controller: RTL and testbench
=====================================

// Module: sar_adc_controller
// PURPOSE
//   Successive-approximation ADC controller: reads an external analog voltage using the R2R ladder
//   as the trial DAC and an external comparator as the decision input. Receive-side counterpart of
//   the triangle PWM/R2R generator. Sits between the FPGA pins (R2R_out, comp_in) and the display path.
//   Converts one WIDTH-bit sample per start request and presents it with a one-cycle valid strobe.
// PARAMETERS
//   WIDTH          8     bit width of R2R_out and result
//   SETTLE_CYCLES  1000  clk cycles the DAC/comparator settle per trial bit (10 us @ 100 MHz); must be >= 2
// PORTS
//   clk           in   1      system clock (100 MHz)
//   reset         in   1      synchronous, active-high reset
//   enable        in   1      active-high enable; low aborts any conversion
//   start         in   1      conversion request, sampled only in IDLE
//   comp_in       in   1      async comparator output: 1 = analog input >= R2R ladder voltage
//   R2R_out       out  WIDTH  trial code driven to R2R ladder (registered)
//   result        out  WIDTH  last completed conversion (registered, held until next completion)
//   result_valid  out  1      one-cycle pulse when result updates
//   busy          out  1      high while state != IDLE
// BEHAVIOUR
//   - Single clock, synchronous active-high reset; reset: state IDLE, R2R_out=0, result=0,
//     result_valid=0, busy=0, synchronizer flops=0. Reset mid-conversion aborts with no result_valid.
//   - comp_in passes through a 2-flop synchronizer -> comp_sync (2-cycle latency, covered by SETTLE_CYCLES>=2).
//   - SETTLE_CYCLES < 2 -> $error at elaboration.
//   - FSM states: IDLE, SETTLE, COMPARE.
//   - IDLE: if enable && start: bit_idx<=WIDTH-1, R2R_out<=1<<(WIDTH-1), cnt<=SETTLE_CYCLES-1, -> SETTLE.
//     Otherwise R2R_out holds 0.
//   - SETTLE: cnt==0 -> COMPARE, else cnt<=cnt-1. Exactly SETTLE_CYCLES cycles spent per bit.
//   - COMPARE (1 cycle): if !comp_sync clear R2R_out[bit_idx] (keep it if comp_sync=1).
//       bit_idx>0: bit_idx--, set R2R_out[bit_idx-1], cnt reload, -> SETTLE.
//       bit_idx==0: result<=final code (with bit 0 decision applied), result_valid<=1, R2R_out<=0, -> IDLE.
//   - Latency: result_valid high in the cycle after edge WIDTH*(SETTLE_CYCLES+1) counted from the edge
//     that accepted start (8*1001 = 8008 cycles at defaults). result_valid otherwise 0.
//   - start while busy: ignored (no queuing). start held high in IDLE: back-to-back conversions,
//     the next accepted on the edge after result_valid's cycle begins (IDLE lasts >= 1 cycle).
//   - enable low in any state: next edge -> IDLE, R2R_out=0, busy=0, result/result_valid unchanged
//     (result_valid forced 0), partial code discarded. enable low with start high: no conversion.
//   - Arithmetic: bit_idx width $clog2(WIDTH); cnt width $clog2(SETTLE_CYCLES); all codes unsigned, no wrap.
// STRUCTURE
//   - sar_adc_pkg: typedef enum logic [1:0] {IDLE, SETTLE, COMPARE} sar_state_t; MIN_SETTLE_CYCLES = 2.
//   - Sub-module sync_2ff (WIDTH=1) for comp_in; FSM, settle counter, and trial register stay inline.
// TESTING (bench comparator model: comp_in = (VIN >= R2R_out), VIN a WIDTH-bit code; SETTLE_CYCLES=4)
//   - VIN=8'hA5, pulse start -> trial sequence 80,C0,A0,B0,A8,A4,A6,A5; result=8'hA5, valid after 40 cycles.
//   - VIN=8'h00 -> result 8'h00; VIN=8'hFF -> result 8'hFF; each with exactly one result_valid pulse.
//   - start pulsed again at cycle 10 of a conversion -> ignored; one result_valid at cycle 40 only.
//   - enable dropped at cycle 20 -> R2R_out=0, busy=0 next cycle, no result_valid, result keeps old value.
//   - reset asserted mid-conversion -> all outputs 0 next cycle; new start afterwards converts correctly.
//   - start held high, VIN changed 8'h10 -> 8'h3C between conversions -> consecutive results 10, 3C.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// ---------------------------------------------------------------------------
// sar_adc_pkg
//   Shared types and constants for the successive-approximation ADC
//   controller.
//   - sar_state_t       : controller FSM state encoding
//   - MIN_SETTLE_CYCLES : smallest legal settle time per trial bit. It covers
//                         the two-flop comparator synchronizer latency.
//   - idx_width()       : width of a bit index into a WIDTH-bit code. Never
//                         returns less than 1.
// ---------------------------------------------------------------------------
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2
  } sar_state_t;

  localparam int MIN_SETTLE_CYCLES = 2;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer. It brings asynchronous level signals into the clk
//   domain. Each bit gets its own independent flop pair.
//   Ports:
//     clk   in  1      system clock
//     reset in  1      synchronous active-high reset, clears both stages
//     d     in  WIDTH  asynchronous input
//     q     out WIDTH  synchronized output (2-cycle latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/sar_adc_controller.sv
// ---------------------------------------------------------------------------
// sar_adc_controller
//   Successive-approximation ADC controller. The R2R ladder acts as the trial
//   DAC, and an external comparator reports whether the analog input is at or
//   above the ladder voltage. The controller converts one WIDTH-bit sample per
//   accepted start request. It presents the finished code with a one-cycle
//   valid strobe.
//   Parameters:
//     WIDTH          code width of R2R_out and result
//     SETTLE_CYCLES  clk cycles allowed for DAC/comparator settling per bit
//   Ports:
//     clk           in   1      system clock
//     reset         in   1      synchronous active-high reset
//     enable        in   1      low aborts any conversion and forces IDLE
//     start         in   1      conversion request, only honoured in IDLE
//     comp_in       in   1      async comparator: 1 = input >= ladder voltage
//     R2R_out       out  WIDTH  trial code driven to the ladder (registered)
//     result        out  WIDTH  last completed conversion (held)
//     result_valid  out  1      one-cycle pulse when result updates
//     busy          out  1      high while a conversion is in progress
// ---------------------------------------------------------------------------
module sar_adc_controller
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             comp_in,
  output logic [WIDTH-1:0] R2R_out,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CODE_MSB   = {1'b1, {(WIDTH-1){1'b0}}};

  // Each trial must outlast the synchronizer latency. Otherwise the
  // comparator decision would belong to the previous trial code.
  generate
    if (SETTLE_CYCLES < MIN_SETTLE_CYCLES) begin : g_settle_check
      $error("sar_adc_controller: SETTLE_CYCLES must be >= %0d", MIN_SETTLE_CYCLES);
    end
  endgenerate

  sar_state_t       state_reg,   state_next;
  logic [WIDTH-1:0] r2r_reg,     r2r_next;
  logic [WIDTH-1:0] result_reg,  result_next;
  logic             valid_reg,   valid_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
  logic [WIDTH-1:0] trial_code;
  logic             comp_sync;

  sync_2ff #(
    .WIDTH (1)
  ) u_comp_sync (
    .clk   (clk),
    .reset (reset),
    .d     (comp_in),
    .q     (comp_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      r2r_reg     <= '0;
      result_reg  <= '0;
      valid_reg   <= 1'b0;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      r2r_reg     <= r2r_next;
      result_reg  <= result_next;
      valid_reg   <= valid_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    r2r_next     = r2r_reg;
    result_next  = result_reg;
    valid_next   = 1'b0;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    trial_code   = r2r_reg;

    if (!enable) begin
      // Abort: discard the partial code. The previous result is kept.
      state_next = IDLE;
      r2r_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          r2r_next = '0;
          if (start) begin
            bit_idx_next = IDX_MSB;
            r2r_next     = CODE_MSB;
            cnt_next     = CNT_RELOAD;
            state_next   = SETTLE;
          end
        end

        SETTLE: begin
          // The counter starts at SETTLE_CYCLES-1 and exits on zero. That
          // gives exactly SETTLE_CYCLES cycles in this state per trial bit.
          if (cnt_reg == '0) begin
            state_next = COMPARE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end

        COMPARE: begin
          // The comparator reads low when the trial is above the input.
          // In that case the trial bit is dropped.
          if (!comp_sync) begin
            trial_code[bit_idx_reg] = 1'b0;
          end
          if (bit_idx_reg != '0) begin
            bit_idx_next             = bit_idx_reg - 1'b1;
            trial_code[bit_idx_next] = 1'b1;
            r2r_next                 = trial_code;
            cnt_next                 = CNT_RELOAD;
            state_next               = SETTLE;
          end else begin
            result_next = trial_code;
            valid_next  = 1'b1;
            r2r_next    = '0;
            state_next  = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
          r2r_next   = '0;
        end
      endcase
    end
  end

  assign R2R_out      = r2r_reg;
  assign result       = result_reg;
  assign result_valid = valid_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_sar_adc_controller.sv
// ---------------------------------------------------------------------------
// tb_sar_adc_controller
//   Bench for sar_adc_controller with WIDTH=8 and SETTLE_CYCLES=4. An ideal
//   comparator (vin >= R2R_out) stands in for the analog front end. Every
//   expected result goes into a queue when start is driven. It is popped
//   when result_valid appears.
// ---------------------------------------------------------------------------
module tb_sar_adc_controller;

  localparam int W    = 8;
  localparam int S    = 4;
  localparam int CONV = W * (S + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         start;
  logic         comp_in;
  logic [W-1:0] r2r_out;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic [W-1:0] vin;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;

  always #5 clk = ~clk;

  assign comp_in = (vin >= r2r_out);

  sar_adc_controller #(
    .WIDTH         (W),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .comp_in      (comp_in),
    .R2R_out      (r2r_out),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  // Trial k of a binary search: the top k bits are already decided, and the
  // next bit down is set.
  function automatic logic [W-1:0] trial_model(input logic [W-1:0] v, input int k);
    logic [W-1:0] all_ones;
    logic [W-1:0] msb;
    all_ones = '1;
    msb      = {1'b1, {(W-1){1'b0}}};
    return (v & ~(all_ones >> k)) | (msb >> k);
  endfunction

  // Runs one conversion from IDLE. If pulse_at >= 0, start is pulsed again at
  // that cycle of the conversion.
  task automatic convert(input logic [W-1:0] v, input int pulse_at);
    int           cyc;
    bit           seen;
    logic [W-1:0] expv;
    logic [W-1:0] tv;
    vin = v;
    exp_q.push_back(v);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    seen  = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL conv_busy v=%h: busy got %b, required 1", v, busy);
    end
    while (!seen && cyc < CONV + 20) begin
      if ((cyc % (S + 1)) == 0 && (cyc / (S + 1)) < W) begin
        tv = trial_model(v, cyc / (S + 1));
        vectors++;
        if (r2r_out !== tv) begin
          miscompares++;
          $display("FAIL trial v=%h cyc=%0d: R2R_out got %h, required %h", v, cyc, r2r_out, tv);
        end
      end
      if (cyc == pulse_at) start = 1'b1;
      else if (cyc == pulse_at + 1) start = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    expv = exp_q.pop_front();
    vectors++;
    if (!seen || cyc != CONV) begin
      miscompares++;
      $display("FAIL latency v=%h: valid at cycle %0d (seen=%0b), required %0d", v, cyc, seen, CONV);
    end
    vectors++;
    if (result !== expv) begin
      miscompares++;
      $display("FAIL result v=%h: got %h, required %h", v, result, expv);
    end
    last_exp = expv;
    @(negedge clk);
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || r2r_out !== '0) begin
      miscompares++;
      $display("FAIL post_conv v=%h: valid/busy/r2r got %b/%b/%h, required 0/0/00",
               v, result_valid, busy, r2r_out);
    end
    $display("conversion vin=%h result=%h cycles=%0d", v, result, cyc);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
    vin    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (r2r_out !== '0 || result !== '0 || result_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: r2r/result/valid/busy got %h/%h/%b/%b, required 00/00/0/0",
               r2r_out, result, result_valid, busy);
    end
    reset    = 1'b0;
    last_exp = '0;
    @(negedge clk);
    $display("reset checked");
  endtask

  task automatic test_basic();
    convert(8'hA5, -1);
    convert(8'h00, -1);
    convert(8'hFF, -1);
  endtask

  task automatic test_start_while_busy();
    convert(8'h5C, 10);
  endtask

  task automatic test_enable_abort();
    int cyc;
    bit spurious;
    vin   = 8'h77;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (r2r_out !== '0 || busy !== 1'b0 || result_valid !== 1'b0 || result !== last_exp) begin
      miscompares++;
      $display("FAIL enable_abort: r2r/busy/valid/result got %h/%b/%b/%h, required 00/0/0/%h",
               r2r_out, busy, result_valid, result, last_exp);
    end
    start    = 1'b1;
    spurious = 1'b0;
    for (cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    vectors++;
    if (spurious) begin
      miscompares++;
      $display("FAIL enable_low_start: valid or busy seen, required neither");
    end
    start  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    $display("enable abort checked, result held at %h", result);
  endtask

  task automatic test_reset_mid();
    vin   = 8'h99;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (r2r_out !== '0 || result !== '0 || result_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: r2r/result/valid/busy got %h/%h/%b/%b, required 00/00/0/0",
               r2r_out, result, result_valid, busy);
    end
    reset    = 1'b0;
    last_exp = '0;
    @(negedge clk);
    $display("mid-conversion reset checked");
    convert(8'h5A, -1);
  endtask

  task automatic test_back_to_back();
    int           cyc;
    bit           seen;
    logic [W-1:0] expv;
    vin = 8'h10;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h3C);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < CONV + 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    expv = exp_q.pop_front();
    vectors++;
    if (!seen || cyc != CONV || result !== expv) begin
      miscompares++;
      $display("FAIL b2b_first: result %h at cycle %0d, required %h at %0d", result, cyc, expv, CONV);
    end
    $display("back-to-back #1 result=%h cycles=%0d", result, cyc);
    vin  = 8'h3C;
    seen = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: busy got %b, required 1", busy);
    end
    while (!seen && cyc < 2 * CONV + 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    expv = exp_q.pop_front();
    vectors++;
    if (!seen || cyc != 2 * CONV + 1 || result !== expv) begin
      miscompares++;
      $display("FAIL b2b_second: result %h at cycle %0d, required %h at %0d",
               result, cyc, expv, 2 * CONV + 1);
    end
    $display("back-to-back #2 result=%h cycles=%0d", result, cyc);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_stop: busy got %b, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_while_busy();
    test_enable_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
